// File: rtl/addr_map_rule_pkg.sv
// rtl/addr_map_rule_pkg.sv - shared address-map rule type, commit states and range helper
package addr_map_rule_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        APPLY
    } addr_map_commit_state_e;

    // End is exclusive, so a rule with start >= end can never match.
    function automatic logic rule_in_range(addr_map_rule_t rule, logic [31:0] addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/addr_map_rule_match.sv
// rtl/addr_map_rule_match.sv - combinational priority matcher, lowest enabled matching slot wins
module addr_map_rule_match
    import addr_map_rule_pkg::*;
#(
    parameter int          NUM_RULES   = 4,
    parameter logic [31:0] DEFAULT_IDX = 32'd0
) (
    input  addr_map_rule_t       rules [NUM_RULES],
    input  logic [NUM_RULES-1:0] en,
    input  logic [31:0]          addr,
    output logic                 hit,
    output logic [31:0]          idx
);

    // Scanning from the top down lets the lowest-numbered match overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = DEFAULT_IDX;
        for (int k = NUM_RULES - 1; k >= 0; k--) begin
            if (en[k] && rule_in_range(rules[k], addr)) begin
                hit = 1'b1;
                idx = rules[k].idx;
            end
        end
    end

endmodule

// File: rtl/addr_map_rule_table.sv
// rtl/addr_map_rule_table.sv - shadow/active rule tables, commit FSM and registered lookup
module addr_map_rule_table
    import addr_map_rule_pkg::*;
#(
    parameter int          NUM_RULES   = 4,
    parameter logic [31:0] DEFAULT_IDX = 32'd0,
    localparam int         SEL_W       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rule_we_i,
    input  logic [SEL_W-1:0] rule_sel_i,
    input  addr_map_rule_t   rule_i,
    input  logic             rule_en_i,
    input  logic             commit_i,
    output logic             commit_busy_o,
    output logic             commit_done_o,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_idx_o,
    output logic             rsp_hit_o
);

    addr_map_commit_state_e state, state_next;

    addr_map_rule_t         shadow_rules [NUM_RULES];
    addr_map_rule_t         active_rules [NUM_RULES];
    logic [NUM_RULES-1:0]   shadow_en;
    logic [NUM_RULES-1:0]   active_en;

    logic                   match_hit;
    logic [31:0]            match_idx;
    logic                   req_fire;

    // Rule fields are qualified by the enables, so only the enables need reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_RULES; k++) begin
            if (rule_we_i && rule_sel_i == SEL_W'(k)) begin
                shadow_rules[k] <= rule_i;
            end
        end
        if (state == APPLY) begin
            active_rules <= shadow_rules;
        end
    end

    // Nonblocking copy gives the active table the pre-write shadow on a collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_en <= '0;
            active_en <= '0;
        end else begin
            if (state == APPLY) begin
                active_en <= shadow_en;
            end
            for (int k = 0; k < NUM_RULES; k++) begin
                if (rule_we_i && rule_sel_i == SEL_W'(k)) begin
                    shadow_en[k] <= rule_en_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        commit_busy_o = 1'b0;
        commit_done_o = 1'b0;
        case (state)
            IDLE: begin
                if (commit_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                commit_busy_o = 1'b1;
                if (!rsp_valid_o || rsp_ready_i) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                commit_busy_o = 1'b1;
                commit_done_o = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready_o = (state == IDLE) && (!rsp_valid_o || rsp_ready_i);
    assign req_fire    = req_valid_i && req_ready_o;

    addr_map_rule_match #(
        .NUM_RULES   (NUM_RULES),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) u_match (
        .rules (active_rules),
        .en    (active_en),
        .addr  (req_addr_i),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= DEFAULT_IDX;
        end else if (req_fire) begin
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= match_hit;
            rsp_idx_o   <= match_idx;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addr_map_rule_table.sv
// tb/tb_addr_map_rule_table.sv - scoreboard bench for addr_map_rule_table
module tb_addr_map_rule_table;
    import addr_map_rule_pkg::*;

    localparam int          NR  = 3;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           rule_we;
    logic [1:0]     rule_sel;
    addr_map_rule_t rule;
    logic           rule_en;
    logic           commit;
    logic           commit_busy;
    logic           commit_done;
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    req_addr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_idx;
    logic           rsp_hit;

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    addr_map_rule_table #(
        .NUM_RULES   (NR),
        .DEFAULT_IDX (DEF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rule_we_i     (rule_we),
        .rule_sel_i    (rule_sel),
        .rule_i        (rule),
        .rule_en_i     (rule_en),
        .commit_i      (commit),
        .commit_busy_o (commit_busy),
        .commit_done_o (commit_done),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_idx_o     (rsp_idx),
        .rsp_hit_o     (rsp_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got hit=%b idx=%h required no response", rsp_hit, rsp_idx);
            end else begin
                mon_e = exp_q.pop_front();
                popped++;
                if (rsp_hit !== mon_e.hit || rsp_idx !== mon_e.idx) begin
                    errors++;
                    $display("FAIL rsp got hit=%b idx=%h required hit=%b idx=%h",
                             rsp_hit, rsp_idx, mon_e.hit, mon_e.idx);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_rule(input logic [1:0] sel, input logic [31:0] i, input logic [31:0] s,
                              input logic [31:0] e, input logic en);
        rule_we  = 1'b1;
        rule_sel = sel;
        rule     = '{idx: i, start_addr: s, end_addr: e};
        rule_en  = en;
        tick();
        rule_we  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] addr, input logic eh, input logic [31:0] ei);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(exp_t'{hit: eh, idx: ei});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lookup_accept addr=%h got ready=0 required acceptance", addr);
        end else if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL lookup_latency addr=%h got rsp_valid=%b required 1", addr, rsp_valid);
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue got %0d outstanding required 0", exp_q.size());
        end
    endtask

    task automatic do_commit();
        bit seen = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (commit_done) seen = 1'b1;
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL commit_done got no pulse required one");
        end
    endtask

    function automatic exp_t ref_stream(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h8000) return exp_t'{hit: 1'b1, idx: 32'd4};
        if (a >= 32'h4000 && a < 32'hC000) return exp_t'{hit: 1'b1, idx: 32'd2};
        return exp_t'{hit: 1'b0, idx: DEF};
    endfunction

    task automatic test_reset();
        rst = 1'b1; rule_we = 1'b0; rule_sel = '0; rule = '0; rule_en = 1'b0;
        commit = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_idx !== DEF ||
            commit_busy !== 1'b0 || commit_done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got v=%b h=%b idx=%h busy=%b done=%b rdy=%b required 0 0 %h 0 0 1",
                     rsp_valid, rsp_hit, rsp_idx, commit_busy, commit_done, req_ready, DEF);
        end
        lookup(32'h1000, 1'b0, DEF);
        wait_drain();
    endtask

    task automatic test_commit_boundaries();
        write_rule(2'd0, 32'd3, 32'h1000, 32'h2000, 1'b1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_drain got busy=%b done=%b rdy=%b required 1 0 0", commit_busy, commit_done, req_ready);
        end
        tick();
        checks++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_apply got busy=%b done=%b rdy=%b required 1 1 0", commit_busy, commit_done, req_ready);
        end
        tick();
        checks++;
        if (commit_busy !== 1'b0 || commit_done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_idle got busy=%b done=%b rdy=%b required 0 0 1", commit_busy, commit_done, req_ready);
        end
        lookup(32'h1000, 1'b1, 32'd3);
        lookup(32'h1FFF, 1'b1, 32'd3);
        lookup(32'h2000, 1'b0, DEF);
        lookup(32'h0FFF, 1'b0, DEF);
        wait_drain();
    endtask

    task automatic test_shadow_collision();
        write_rule(2'd0, 32'd7, 32'h1000, 32'h2000, 1'b1);
        lookup(32'h1000, 1'b1, 32'd3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        checks++;
        if (commit_done !== 1'b1) begin
            errors++;
            $display("FAIL collision_apply got done=%b required 1", commit_done);
        end
        write_rule(2'd0, 32'd9, 32'h1000, 32'h2000, 1'b1);
        lookup(32'h1000, 1'b1, 32'd7);
        do_commit();
        lookup(32'h1000, 1'b1, 32'd9);
        wait_drain();
    endtask

    task automatic test_priority();
        write_rule(2'd0, 32'd1, 32'h1000, 32'h8000, 1'b1);
        write_rule(2'd1, 32'd2, 32'h4000, 32'hC000, 1'b1);
        write_rule(2'd2, 32'd5, 32'h0100, 32'h0100, 1'b1);
        write_rule(2'd3, 32'd8, 32'h0000, 32'hFFFF_FFFF, 1'b1);
        do_commit();
        lookup(32'h5000, 1'b1, 32'd1);
        lookup(32'h9000, 1'b1, 32'd2);
        lookup(32'h0100, 1'b0, DEF);
        lookup(32'h4000, 1'b1, 32'd1);
        lookup(32'hBFFF, 1'b1, 32'd2);
        lookup(32'hC000, 1'b0, DEF);
        lookup(32'hD000, 1'b0, DEF);
        wait_drain();
    endtask

    task automatic test_drain();
        int dn = 0;
        rsp_ready = 1'b0;
        lookup(32'h5000, 1'b1, 32'd1);
        write_rule(2'd0, 32'd4, 32'h1000, 32'h8000, 1'b1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (commit_busy !== 1'b1 || commit_done !== 1'b0 || req_ready !== 1'b0 ||
                rsp_valid !== 1'b1 || rsp_idx !== 32'd1 || rsp_hit !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold got busy=%b done=%b rdy=%b v=%b idx=%h required 1 0 0 1 00000001",
                         commit_busy, commit_done, req_ready, rsp_valid, rsp_idx);
            end
            tick();
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (commit_done) dn++;
        end
        checks++;
        if (dn != 1 || commit_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_release got done_pulses=%0d busy=%b required 1 0", dn, commit_busy);
        end
        lookup(32'h5000, 1'b1, 32'd4);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int   base = popped;
        exp_t e;
        bit   ok;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 32'($urandom_range(0, 32'hFFFF));
            e = ref_stream(a);
            req_valid = 1'b1;
            req_addr  = a;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                if (req_ready) begin
                    exp_q.push_back(e);
                    ok = 1'b1;
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'($urandom_range(0, 1));
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL stream_accept item=%0d got no acceptance required acceptance", i);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        checks++;
        if (popped - base != 16) begin
            errors++;
            $display("FAIL stream_count got %0d responses required 16", popped - base);
        end
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        lookup(32'h5000, 1'b1, 32'd4);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        checks++;
        if (commit_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_drain got busy=%b required 1", commit_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_idx !== DEF ||
            commit_busy !== 1'b0 || commit_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got v=%b h=%b idx=%h busy=%b done=%b required 0 0 %h 0 0",
                     rsp_valid, rsp_hit, rsp_idx, commit_busy, commit_done, DEF);
        end
        exp_q.delete();
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        lookup(32'h5000, 1'b0, DEF);
        wait_drain();
        do_commit();
        lookup(32'h5000, 1'b0, DEF);
        lookup(32'h9000, 1'b0, DEF);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_commit_boundaries();
        test_shadow_collision();
        test_priority();
        test_drain();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
